pe_array_io: RTL and testbench
==============================

// Module: pe_array_io
// PURPOSE
//  Parametrised scatter/gather front-end for a PE array. It distributes an input sample
//  stream to PE_NUM lanes in LOAD_NUM-word bursts, and collects per-lane PE results
//  through per-lane FIFOs and a round-robin arbiter into one output stream with
//  valid/ready backpressure. It sits between the overlay I/O and the PE instances,
//  and reports lane tags and overflow.
// PARAMETERS
//  DATA_WIDTH  16  real/imag component width; every sample bus is 2*DATA_WIDTH
//  PE_NUM      8   number of PE lanes (>=2)
//  LOAD_NUM    4   words per lane per frame; frame = PE_NUM*LOAD_NUM words
//  FIFO_DEPTH  4   per-lane output FIFO depth (power of 2, >=2)
// PORTS
//  clk           in   1                    clock, all logic on rising edge
//  rst           in   1                    asynchronous reset, active-low
//  load          in   1                    sync restart: clears counters, FIFOs, flags
//  din_v         in   1                    input sample valid
//  din           in   2*DATA_WIDTH         input sample
//  din_rdy       out  1                    input accepted when din_v&din_rdy
//  pe_in_v       out  PE_NUM               per-lane load valid
//  pe_in         out  PE_NUM*2*DATA_WIDTH  per-lane load data, lane i at [i*2DW +: 2DW]
//  frame_done    out  1                    pulse with last word of a frame
//  pe_out_v      in   PE_NUM               per-lane result valid
//  pe_out        in   PE_NUM*2*DATA_WIDTH  per-lane result data
//  dout_v        out  1                    output valid
//  dout          out  2*DATA_WIDTH         output sample
//  dout_lane     out  clog2(PE_NUM)        source lane of dout
//  dout_rdy      in   1                    downstream ready
//  overflow      out  PE_NUM               sticky per-lane FIFO overflow
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0 except din_rdy=0; word_cnt=0, rr_ptr=0, FIFOs empty.
//  din_rdy = 1 whenever out of reset and load=0; load has priority over din_v.
//  Scatter: word_cnt (0..PE_NUM*LOAD_NUM-1) increments only on an accepted word.
//   Gaps in din_v do not reset word_cnt. The accepted word goes to lane word_cnt/LOAD_NUM.
//   pe_in_v[lane]=1 and pe_in lane=din one cycle after acceptance (registered).
//   Non-selected lanes have valid 0 and data 0. frame_done=1 in the same cycle as the
//   pe_in_v of word PE_NUM*LOAD_NUM-1; word_cnt then wraps to 0.
//  Gather FIFO per lane: push when pe_out_v[i]. The push is accepted if count<FIFO_DEPTH
//   or a pop of that lane occurs in the same cycle. Otherwise the word is dropped and
//   overflow[i] is set; it stays set until load or reset.
//  Arbiter: grants the first non-empty lane scanning rr_ptr, rr_ptr+1, ... (mod PE_NUM).
//   A pop happens when a lane is granted and the output register is empty or consumed
//   (!dout_v | dout_rdy). On a pop: rr_ptr <= grant+1 mod PE_NUM.
//  Output register: loads the popped word plus lane tag and sets dout_v. If
//   dout_v&!dout_rdy, dout/dout_lane/dout_v hold stable. If consumed with no new pop:
//   dout_v=0 and dout=0.
//  Minimum latency pe_out_v -> dout_v is 2 cycles (FIFO write, then output register).
//   Sustained throughput is 1 word/cycle.
//  load=1 (sync, any cycle, including mid-frame or while dout stalled): next cycle
//   word_cnt=0, rr_ptr=0, all FIFOs empty, overflow=0, dout_v=0, pe_in_v=0, frame_done=0.
//   pe_out_v arriving during load is discarded.
//  Reset asserted mid-operation behaves identically to load, asynchronously.
// TESTING (bench: PE_NUM=4, LOAD_NUM=2, FIFO_DEPTH=4, DATA_WIDTH=16)
//  8 back-to-back words 0x1..0x8 -> lane0 gets 1,2, lane1 3,4, lane2 5,6, lane3 7,8.
//   frame_done pulses with word 8; a 9th word goes to lane0.
//  Words 1..3, din_v low 5 cycles, words 4..8 -> same lane mapping as the first test
//   (the gap does not reset word_cnt).
//  pe_out_v=4'b1111 for one cycle with data A,B,C,D, dout_rdy=1 -> dout A,B,C,D on
//   4 consecutive cycles with dout_lane 0,1,2,3, first 2 cycles after input.
//  dout_rdy=0, lane2 pushes 6 words -> overflow=4'b0100, words 5,6 lost. Then
//   dout_rdy=1 -> words 1..4 out in order with dout stable while stalled.
//  Lane1 full with dout_rdy=1 and a simultaneous push and pop -> push accepted,
//   overflow stays 0.
//  load mid-frame after 3 words, with 2 words queued in FIFOs -> next cycle
//   dout_v=0, overflow=0. The next input word goes to lane0.

Source files
------------

// File: rtl/pe_array_io.sv
// pe_array_io: scatter/gather front-end between the overlay I/O and a PE array
//   Scatter: accepted din words go to lane word_cnt/LOAD_NUM, registered onto pe_in/pe_in_v.
//   Gather:  per-lane result FIFOs drain through a round-robin arbiter into one dout stream.
// Ports:
//   clk, rst (async, active-low), load (sync restart of counters, FIFOs and flags)
//   din_v/din/din_rdy           input sample stream
//   pe_in_v/pe_in/frame_done    per-lane load bus, frame_done marks the last word of a frame
//   pe_out_v/pe_out             per-lane PE results
//   dout_v/dout/dout_lane/dout_rdy  output stream with source lane tag
//   overflow                    sticky per-lane FIFO drop flag
module pe_array_io #(
    parameter int DATA_WIDTH = 16,
    parameter int PE_NUM     = 8,
    parameter int LOAD_NUM   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load,
    input  logic                           din_v,
    input  logic [2*DATA_WIDTH-1:0]        din,
    output logic                           din_rdy,
    output logic [PE_NUM-1:0]              pe_in_v,
    output logic [PE_NUM*2*DATA_WIDTH-1:0] pe_in,
    output logic                           frame_done,
    input  logic [PE_NUM-1:0]              pe_out_v,
    input  logic [PE_NUM*2*DATA_WIDTH-1:0] pe_out,
    output logic                           dout_v,
    output logic [2*DATA_WIDTH-1:0]        dout,
    output logic [$clog2(PE_NUM)-1:0]      dout_lane,
    input  logic                           dout_rdy,
    output logic [PE_NUM-1:0]              overflow
);
    localparam int DW2 = 2*DATA_WIDTH;
    localparam int LW  = $clog2(PE_NUM);
    localparam int SW  = LOAD_NUM > 1 ? $clog2(LOAD_NUM) : 1;
    localparam int FW  = $clog2(FIFO_DEPTH);

    // (a + b) mod PE_NUM for b < PE_NUM, valid for non-power-of-2 lane counts
    function automatic logic [LW-1:0] wrap_inc(input logic [LW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        return LW'(s >= PE_NUM ? s - PE_NUM : s);
    endfunction

    // ---------------- scatter ----------------
    // word_cnt is kept split as lane_cnt/sub_cnt so the lane select needs no divider
    logic                  run;
    logic [SW-1:0]         sub_cnt;
    logic [LW-1:0]         lane_cnt;
    logic                  accept;
    logic                  last_sub;
    logic                  last_word;
    logic [PE_NUM*DW2-1:0] pe_in_nxt;

    assign din_rdy   = run & ~load;
    assign accept    = din_v & din_rdy;
    assign last_sub  = sub_cnt == SW'(LOAD_NUM-1);
    assign last_word = last_sub && lane_cnt == LW'(PE_NUM-1);

    always_comb begin
        pe_in_nxt = '0;
        for (int i = 0; i < PE_NUM; i++)
            if (lane_cnt == LW'(i)) pe_in_nxt[i*DW2 +: DW2] = din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run        <= 1'b0;
            sub_cnt    <= '0;
            lane_cnt   <= '0;
            pe_in_v    <= '0;
            pe_in      <= '0;
            frame_done <= 1'b0;
        end else begin
            run        <= 1'b1;
            pe_in_v    <= accept ? PE_NUM'(1) << lane_cnt : '0;
            pe_in      <= accept ? pe_in_nxt : '0;
            frame_done <= accept & last_word;
            if (load) begin
                sub_cnt  <= '0;
                lane_cnt <= '0;
            end else if (accept) begin
                sub_cnt  <= last_sub ? '0 : sub_cnt + SW'(1);
                lane_cnt <= !last_sub ? lane_cnt : last_word ? '0 : lane_cnt + LW'(1);
            end
        end
    end

    // ---------------- gather FIFOs ----------------
    logic [DW2-1:0]    mem    [PE_NUM][FIFO_DEPTH];
    logic [FW-1:0]     wr_ptr [PE_NUM];
    logic [FW-1:0]     rd_ptr [PE_NUM];
    logic [FW:0]       cnt    [PE_NUM];
    logic [PE_NUM-1:0] ne;
    logic [PE_NUM-1:0] push;
    logic [PE_NUM-1:0] pop;
    logic [LW-1:0]     rr_ptr;
    logic [LW-1:0]     gnt;
    logic              gnt_v;
    logic              take;

    always_comb begin
        ne = '0;
        for (int i = 0; i < PE_NUM; i++) ne[i] = cnt[i] != '0;
    end

    // a full lane still accepts when it is popped in the same cycle
    always_comb begin
        push = '0;
        for (int i = 0; i < PE_NUM; i++)
            push[i] = pe_out_v[i] & ~load & (cnt[i] != (FW+1)'(FIFO_DEPTH) | pop[i]);
    end

    // first non-empty lane from rr_ptr upward; descending loop lets the nearest win
    always_comb begin
        gnt_v = 1'b0;
        gnt   = '0;
        for (int k = PE_NUM-1; k >= 0; k--)
            if (ne[wrap_inc(rr_ptr, k)]) begin
                gnt_v = 1'b1;
                gnt   = wrap_inc(rr_ptr, k);
            end
    end

    assign take = gnt_v & (~dout_v | dout_rdy) & ~load;
    assign pop  = take ? PE_NUM'(1) << gnt : '0;

    always_ff @(posedge clk) begin
        for (int i = 0; i < PE_NUM; i++)
            if (push[i]) mem[i][wr_ptr[i]] <= pe_out[i*DW2 +: DW2];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PE_NUM; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
            overflow <= '0;
        end else if (load) begin
            for (int i = 0; i < PE_NUM; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
            overflow <= '0;
        end else begin
            for (int i = 0; i < PE_NUM; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + FW'(1);
                if (pop[i]) rd_ptr[i] <= rd_ptr[i] + FW'(1);
                cnt[i] <= cnt[i] + (FW+1)'(push[i]) - (FW+1)'(pop[i]);
            end
            overflow <= overflow | (pe_out_v & ~push);
        end
    end

    // ---------------- output register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_v    <= 1'b0;
            dout      <= '0;
            dout_lane <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            dout_v    <= 1'b0;
            dout      <= '0;
            dout_lane <= '0;
            rr_ptr    <= '0;
        end else if (take) begin
            dout_v    <= 1'b1;
            dout      <= mem[gnt][rd_ptr[gnt]];
            dout_lane <= gnt;
            rr_ptr    <= wrap_inc(gnt, 1);
        end else if (dout_rdy) begin
            dout_v    <= 1'b0;
            dout      <= '0;
            dout_lane <= '0;
        end
    end
endmodule

// File: tb/tb_pe_array_io.sv
// tb_pe_array_io: scoreboard bench for pe_array_io (PE_NUM=4, LOAD_NUM=2, FIFO_DEPTH=4)
module tb_pe_array_io;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         load = 1'b0;
    logic         din_v = 1'b0;
    logic [31:0]  din = '0;
    logic         din_rdy;
    logic [3:0]   pe_in_v;
    logic [127:0] pe_in;
    logic         frame_done;
    logic [3:0]   pe_out_v = '0;
    logic [127:0] pe_out = '0;
    logic         dout_v;
    logic [31:0]  dout;
    logic [1:0]   dout_lane;
    logic         dout_rdy = 1'b0;
    logic [3:0]   overflow;

    pe_array_io #(.DATA_WIDTH(16), .PE_NUM(4), .LOAD_NUM(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .load(load), .din_v(din_v), .din(din), .din_rdy(din_rdy),
        .pe_in_v(pe_in_v), .pe_in(pe_in), .frame_done(frame_done),
        .pe_out_v(pe_out_v), .pe_out(pe_out), .dout_v(dout_v), .dout(dout),
        .dout_lane(dout_lane), .dout_rdy(dout_rdy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [1:0] lane; logic [31:0] d; logic fd; } sc_t;
    typedef struct packed { logic [1:0] lane; logic [31:0] d; } ga_t;
    sc_t sq[$];
    ga_t gq[$];
    sc_t se;
    ga_t ge;
    int vecs = 0;
    int errs = 0;
    logic [1:0] ln1 [8] = '{0, 0, 1, 1, 2, 2, 3, 3};

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] lanew(input int ln, input logic [31:0] w);
        return 128'(w) << (32*ln);
    endfunction

    task automatic send(input logic [31:0] d, input logic [1:0] ln, input logic fd);
        din_v = 1'b1;
        din   = d;
        sq.push_back('{ln, d, fd});
        @(posedge clk); #1;
        din_v = 1'b0;
        din   = '0;
    endtask

    task automatic pout(input logic [3:0] v, input logic [127:0] d);
        pe_out_v = v;
        pe_out   = d;
        @(posedge clk); #1;
        pe_out_v = '0;
        pe_out   = '0;
    endtask

    task automatic drain();
        int t = 0;
        while (gq.size() != 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        chk("drain_pending", 128'(gq.size()), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // monitor: scatter + gather scoreboards and stall stability
    logic        prev_stall = 1'b0;
    logic [31:0] prev_d = '0;
    logic [1:0]  prev_l = '0;
    always @(negedge clk) begin
        if (rst) begin
            if (pe_in_v != 0 || frame_done) begin
                if (sq.size() == 0) chk("scatter_unexpected", {pe_in_v, frame_done}, 0);
                else begin
                    se = sq.pop_front();
                    chk("pe_in_v", pe_in_v, 4'b1 << se.lane);
                    chk("pe_in", pe_in, lanew(se.lane, se.d));
                    chk("frame_done", frame_done, se.fd);
                end
            end
            if (prev_stall) begin
                chk("stall_v", dout_v, 1);
                chk("stall_dout", dout, prev_d);
                chk("stall_lane", dout_lane, prev_l);
            end
            if (dout_v && dout_rdy) begin
                if (gq.size() == 0) chk("gather_unexpected", {dout_lane, dout}, 0);
                else begin
                    ge = gq.pop_front();
                    chk("dout", dout, ge.d);
                    chk("dout_lane", dout_lane, ge.lane);
                end
            end
            prev_stall = dout_v & ~dout_rdy & ~load;
            prev_d     = dout;
            prev_l     = dout_lane;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_din_rdy", din_rdy, 0);
        chk("rst_dout_v", dout_v, 0);
        chk("rst_dout", dout, 0);
        chk("rst_pe_in_v", pe_in_v, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overflow", overflow, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("din_rdy", din_rdy, 1);

        // frame of 8, a 9th word to lane0, then the rest of that frame to realign
        for (int i = 0; i < 8; i++) send(32'(i + 1), ln1[i], i == 7);
        send(32'h9, 2'd0, 1'b0);
        for (int i = 1; i < 8; i++) send(32'h10 + 32'(i), ln1[i], i == 7);
        @(posedge clk); #1;

        // gap in din_v keeps the word position
        for (int i = 0; i < 3; i++) send(32'h100 + 32'(i), ln1[i], 1'b0);
        repeat (5) @(posedge clk);
        #1;
        for (int i = 3; i < 8; i++) send(32'h100 + 32'(i), ln1[i], i == 7);
        @(posedge clk); #1;

        // four lanes at once: 2-cycle latency, then one word per cycle
        dout_rdy = 1'b1;
        for (int i = 0; i < 4; i++) gq.push_back('{2'(i), 32'hA0 + 32'(i)});
        pe_out_v = 4'hf;
        pe_out   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            pe_out_v = '0;
            pe_out   = '0;
            chk("lat_dout_v", dout_v, k >= 1 && k <= 4);
        end
        drain();

        // stalled output, lane2 overflows with words 5,6
        dout_rdy = 1'b0;
        gq.push_back('{2'd0, 32'hB00});
        pout(4'b0001, lanew(0, 32'hB00));
        repeat (2) @(posedge clk);
        #1;
        for (int i = 1; i <= 4; i++) gq.push_back('{2'd2, 32'h2000 + 32'(i)});
        for (int i = 1; i <= 6; i++) pout(4'b0100, lanew(2, 32'h2000 + 32'(i)));
        @(posedge clk); #1;
        chk("ovf_lane2", overflow, 4'b0100);
        dout_rdy = 1'b1;
        drain();
        chk("ovf_sticky", overflow, 4'b0100);

        // lane1 full, push and pop in the same cycle
        dout_rdy = 1'b0;
        for (int i = 1; i <= 6; i++) gq.push_back('{2'd1, 32'h3000 + 32'(i)});
        for (int i = 1; i <= 5; i++) pout(4'b0010, lanew(1, 32'h3000 + 32'(i)));
        dout_rdy = 1'b1;
        pout(4'b0010, lanew(1, 32'h3006));
        drain();
        chk("ovf_lane1", overflow[1], 0);

        // load mid-frame with words queued and an overflow flag set
        dout_rdy = 1'b0;
        for (int i = 1; i <= 3; i++) pout(4'b1000, lanew(3, 32'h4100 + 32'(i)));
        for (int i = 1; i <= 5; i++) pout(4'b0001, lanew(0, 32'h4200 + 32'(i)));
        @(posedge clk); #1;
        chk("ovf_pre_load", overflow, 4'b0101);
        send(32'h4001, 2'd0, 1'b0);
        send(32'h4002, 2'd0, 1'b0);
        send(32'h4003, 2'd1, 1'b0);
        load     = 1'b1;
        pe_out_v = 4'b0100;
        pe_out   = lanew(2, 32'hDEAD);
        #1;
        chk("load_din_rdy", din_rdy, 0);
        @(posedge clk); #1;
        load     = 1'b0;
        pe_out_v = '0;
        pe_out   = '0;
        chk("load_dout_v", dout_v, 0);
        chk("load_overflow", overflow, 0);
        chk("load_pe_in_v", pe_in_v, 0);
        chk("load_frame_done", frame_done, 0);
        send(32'h5001, 2'd0, 1'b0);
        dout_rdy = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("load_fifos_empty", dout_v, 0);
        gq.push_back('{2'd1, 32'h6001});
        gq.push_back('{2'd3, 32'h6003});
        pout(4'b1010, lanew(1, 32'h6001) | lanew(3, 32'h6003));
        drain();

        chk("scatter_pending", 128'(sq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
